// File: rtl/alu_operand_sel.sv
// ALU B-operand selector: decodes a select code into a bus source, the step constant or zero, and buffers it in a 2-entry skid buffer.
// Latency: 1 cycle from accept to alu_b/out_valid when the buffer is empty.
// Backpressure: in_ready is registered and high while the skid entry is empty; operands hold steady while out_ready is low.
// Optional build macro ALU_OPERAND_SEL_ERRCNT_EN adds a 16-bit saturating err_cnt output counting illegal-select accepts.
module alu_operand_sel #(
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 3,
    parameter int STEP_CONST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         alu_b,
    output logic                      sel_err,
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
    output logic [15:0]               err_cnt,
`endif
    input  logic                      err_clr
);

    localparam logic [DATA_W-1:0] STEP_VAL = DATA_W'(STEP_CONST);

    logic [DATA_W-1:0] mainDat, skidDat, newDat;
    logic [DATA_W-1:0] mainDatNxt, skidDatNxt;
    logic              mainVld, skidVld, mainVldNxt, skidVldNxt;
    logic              inRdyQ, selErrQ;
    logic              isIllegal, accept, pop;

    assign accept = in_valid & inRdyQ;
    assign pop    = mainVld & out_ready;

    // Decode the select code into the operand value and an illegal flag.
    always_comb begin
        newDat    = '0;
        isIllegal = 1'b0;
        if (sel == SEL_W'(NUM_SRC)) begin
            newDat = STEP_VAL;
        end else if (sel == SEL_W'(NUM_SRC + 1)) begin
            newDat = '0;
        end else if (sel > SEL_W'(NUM_SRC + 1)) begin
            isIllegal = 1'b1;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (sel == SEL_W'(k)) begin
                    newDat = src_bus[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Skid-buffer next state: a pop refills main from skid first, otherwise from the new operand.
    always_comb begin
        mainVldNxt = mainVld;
        mainDatNxt = mainDat;
        skidVldNxt = skidVld;
        skidDatNxt = skidDat;
        if (pop) begin
            if (skidVld) begin
                // in_ready is low whenever skid is full, so no accept can collide here.
                mainDatNxt = skidDat;
                skidVldNxt = 1'b0;
            end else if (accept) begin
                mainDatNxt = newDat;
            end else begin
                mainVldNxt = 1'b0;
            end
        end else if (accept) begin
            if (!mainVld) begin
                mainVldNxt = 1'b1;
                mainDatNxt = newDat;
            end else begin
                skidVldNxt = 1'b1;
                skidDatNxt = newDat;
            end
        end
    end

    // Buffer registers; in_ready tracks the next skid state so it is a pure flop output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainVld <= 1'b0;
            mainDat <= '0;
            skidVld <= 1'b0;
            skidDat <= '0;
            inRdyQ  <= 1'b0;
        end else begin
            mainVld <= mainVldNxt;
            mainDat <= mainDatNxt;
            skidVld <= skidVldNxt;
            skidDat <= skidDatNxt;
            inRdyQ  <= !skidVldNxt;
        end
    end

    // Sticky illegal-select flag; a new illegal accept beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selErrQ <= 1'b0;
        end else if (accept && isIllegal) begin
            selErrQ <= 1'b1;
        end else if (err_clr) begin
            selErrQ <= 1'b0;
        end
    end

`ifdef ALU_OPERAND_SEL_ERRCNT_EN
    logic [15:0] errCntQ;

    // Saturating illegal-accept counter; clear plus illegal accept on one edge leaves a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCntQ <= '0;
        end else if (accept && isIllegal) begin
            if (err_clr) begin
                errCntQ <= 16'd1;
            end else if (errCntQ != 16'hFFFF) begin
                errCntQ <= errCntQ + 16'd1;
            end
        end else if (err_clr) begin
            errCntQ <= '0;
        end
    end

    assign err_cnt = errCntQ;
`endif

    assign in_ready  = inRdyQ;
    assign out_valid = mainVld;
    assign alu_b     = mainDat;
    assign sel_err   = selErrQ;

endmodule
